// File: rtl/peripheral_dbg_pu_riscv_ahb_slave_mem.sv
// peripheral_dbg_pu_riscv_ahb_slave_mem: AHB-Lite scratch RAM with wait states and ERROR responses; PERIPHERAL_DBG_AHB_SLAVE_PRIV_EN rejects user-mode writes
module peripheral_dbg_pu_riscv_ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] dp_idx;
  logic [1:0] dp_lo, dp_size;
  logic dp_write, dp_valid;
  logic accept, err_req, priv_err, done, we;
  logic [3:0] be;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic unused;
  assign unused = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0]};
  assign accept = HSEL & HREADY & HTRANS[1];
  assign word_addr = HADDR >> 2;
`ifdef PERIPHERAL_DBG_AHB_SLAVE_PRIV_EN
  assign priv_err = HWRITE & ~HPROT[1];
`else
  assign priv_err = 1'b0;
`endif
  assign err_req = (word_addr >= ADDR_WIDTH'(MEM_DEPTH)) | (HSIZE > 3'd2) |
                   ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0])) | priv_err;
  assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
  assign HRESP = (state == S_ERR1) || (state == S_ERR2);
  assign done = dp_valid & (state == S_IDLE);
  assign we = done & dp_write;
  assign HRDATA = (done & ~dp_write) ? mem[dp_idx] : '0;
  assign be = (dp_size == 2'd0) ? 4'b0001 << dp_lo :
              (dp_size == 2'd1) ? (dp_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // next state: errors skip wait states, ERR2 accepts like IDLE
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == S_WAIT) begin
      state_n = (cnt == 4'd0) ? S_IDLE : S_WAIT;
      cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    end else if (state == S_ERR1) begin
      state_n = S_ERR2;
    end else if (accept) begin
      state_n = err_req ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_IDLE);
      cnt_n = (!err_req && WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : cnt;
    end else begin
      state_n = S_IDLE;
    end
  end
  // state, counter and latched address-phase information
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
      cnt <= '0;
      dp_idx <= '0;
      dp_lo <= '0;
      dp_size <= '0;
      dp_write <= 1'b0;
      dp_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dp_valid <= accept ? ~err_req : ((state == S_WAIT) ? dp_valid : 1'b0);
      if (accept) begin
        dp_idx <= word_addr[AW-1:0];
        dp_lo <= HADDR[1:0];
        dp_size <= HSIZE[1:0];
        dp_write <= HWRITE;
      end
    end
  end
  // byte-lane memory write at the edge ending an OKAY write data phase
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < 4; b++)
      if (we && be[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
  end
endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_ahb_slave_mem.sv
// tb_peripheral_dbg_pu_riscv_ahb_slave_mem: random and directed AHB checks of a zero-wait and a three-wait instance
module tb_peripheral_dbg_pu_riscv_ahb_slave_mem;
  logic clk = 0, rst = 1;
  logic hsel0 = 0, hsel3 = 0, hwrite = 0, hmastlock = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic [3:0] hprot = 4'b0011;
  logic [1:0] htrans = 0;
  logic [31:0] rd0, rd3, hrdata;
  logic ro0, ro3, rs0, rs3, hready, hresp;
  logic dsel = 0;
  logic [31:0] m0 [257], m3 [257];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign hready = dsel ? ro3 : ro0;
  assign hresp = dsel ? rs3 : rs0;
  assign hrdata = dsel ? rd3 : rd0;
  always @(posedge clk) if (hready) dsel <= hsel3;
  peripheral_dbg_pu_riscv_ahb_slave_mem #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rd0),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ro0), .HRESP(rs0));
  peripheral_dbg_pu_riscv_ahb_slave_mem #(.WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rd3),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ro3), .HRESP(rs3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one isolated transfer; expectations come from the access rules and the memory model
  task automatic xfer(input bit s, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [3:0] prot, input logic [31:0] wd);
    int idx = int'(a >> 2);
    int off = int'(a % 4);
    int waits = 0;
    bit err;
    logic wresp = 0;
    logic [31:0] wdat = 0, exp = 0;
    err = (idx >= 256) || (sz > 2) || (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
`ifdef PERIPHERAL_DBG_AHB_SLAVE_PRIV_EN
    if (wr && !prot[1]) err = 1;
`endif
    if (!err) exp = s ? m3[idx] : m0[idx];
    @(negedge clk);
    hsel0 = !s; hsel3 = s; haddr = a; hwrite = wr; hsize = sz; hprot = prot; htrans = 2'd2;
    @(posedge clk);
    @(negedge clk);
    htrans = 2'd0; hsel0 = 0; hsel3 = 0; hwdata = wd;
    while (!hready && waits < 40) begin
      wresp |= hresp;
      wdat |= hrdata;
      waits++;
      @(negedge clk);
    end
    check("waits", waits, err ? 1 : (s ? 3 : 0));
    check("wait_resp", wresp, err);
    check("wait_data", wdat, 0);
    check("resp", hresp, err);
    if (!wr) check("rdata", hrdata, exp);
    @(posedge clk);
    if (!err && wr)
      for (int b = 0; b < 4; b++)
        if (b >= off && b < off + (1 << sz)) begin
          if (s) m3[idx][8*b +: 8] = wd[8*b +: 8];
          else m0[idx][8*b +: 8] = wd[8*b +: 8];
        end
  endtask
  initial begin
    logic [31:0] v;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", ro0, 1); check("rst_resp0", rs0, 0); check("rst_data0", rd0, 0);
    check("rst_ready3", ro3, 1); check("rst_resp3", rs3, 0); check("rst_data3", rd3, 0);
    @(negedge clk); rst = 0;
    @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      xfer(0, 1, 32'(i * 4), 2, 4'b0011, $urandom);
      xfer(1, 1, 32'(i * 4), 2, 4'b0011, $urandom);
    end
    xfer(0, 1, 32'h10, 2, 4'b0011, 32'hDEADBEEF);
    xfer(0, 0, 32'h10, 2, 4'b0011, 0);
    xfer(0, 1, 32'h10, 2, 4'b0011, 32'h11223344);
    xfer(0, 1, 32'h11, 0, 4'b0011, 32'h0000AA00);
    xfer(0, 0, 32'h10, 2, 4'b0011, 0);
    xfer(0, 1, 32'h12, 1, 4'b0011, 32'hBEEF0000);
    xfer(0, 0, 32'h10, 2, 4'b0011, 0);
    check("model_byte_half", m0[4], 32'hBEEFAA44);
    xfer(1, 0, 32'h20, 2, 4'b0011, 0);
    @(negedge clk);
    hsel0 = 1; haddr = 32'h400; hwrite = 0; hsize = 2; htrans = 2'd2;
    @(posedge clk);
    @(negedge clk);
    htrans = 0; hsel0 = 0;
    check("err1_ready", hready, 0); check("err1_resp", hresp, 1); check("err1_data", hrdata, 0);
    @(posedge clk);
    @(negedge clk);
    check("err2_ready", hready, 1); check("err2_resp", hresp, 1); check("err2_data", hrdata, 0);
    v = $urandom;
    hsel0 = 1; haddr = 0; hwrite = 1; hsize = 2; hprot = 4'b0011; htrans = 2'd2;
    @(posedge clk);
    @(negedge clk);
    htrans = 0; hsel0 = 0; hwdata = v;
    check("err2_acc_ready", hready, 1); check("err2_acc_resp", hresp, 0);
    @(posedge clk);
    m0[0] = v;
    xfer(0, 0, 0, 2, 4'b0011, 0);
    xfer(0, 1, 32'h02, 2, 4'b0011, $urandom);
    xfer(0, 0, 32'h00, 2, 4'b0011, 0);
    xfer(1, 1, 32'h02, 2, 4'b0011, $urandom);
    xfer(1, 0, 32'h00, 2, 4'b0011, 0);
    xfer(0, 1, 32'h30, 2, 4'b0001, 32'hCAFE0001);
    xfer(0, 0, 32'h30, 2, 4'b0011, 0);
    xfer(0, 1, 32'h30, 2, 4'b0011, 32'hCAFE0003);
    xfer(0, 0, 32'h30, 2, 4'b0011, 0);
    v = $urandom;
    @(negedge clk);
    hsel0 = 1; haddr = 32'h40; hwrite = 1; hsize = 2; htrans = 2'd2;
    @(posedge clk);
    @(negedge clk);
    hwdata = v; hwrite = 0;
    check("raw_wr_ready", hready, 1); check("raw_wr_resp", hresp, 0);
    @(posedge clk);
    @(negedge clk);
    htrans = 0; hsel0 = 0;
    m0[16] = v;
    check("raw_rd_ready", hready, 1); check("raw_rd_data", hrdata, v);
    @(posedge clk);
    @(negedge clk);
    hsel3 = 1; haddr = 32'h14; hwrite = 1; hsize = 2; htrans = 2'd2;
    @(posedge clk);
    @(negedge clk);
    htrans = 0; hsel3 = 0; hwdata = ~m3[5];
    check("mid_wait_low", ro3, 0);
    #2 rst = 1;
    #1;
    check("mid_rst_ready", ro3, 1); check("mid_rst_resp", rs3, 0); check("mid_rst_data", rd3, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    xfer(1, 0, 32'h14, 2, 4'b0011, 0);
    for (int n = 0; n < 200; n++) begin
      int idx = ($urandom_range(0, 9) == 0) ? 256 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      logic [2:0] sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'(idx * 4 + int'($urandom_range(0, 3))),
           sz, 4'b0011, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
